perf_cntr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one perf_cntr MMIO port among N_REQ requesters (cores/debug).

---
 rtl/perf_pkg.sv | 20 ++
 rtl/rr_pick.sv | 27 ++
 rtl/perf_cntr_arbiter.sv | 93 +++++++++
 tb/tb_perf_cntr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the perf_cntr MMIO port: register map, control encodings and arbiter FSM states.
package perf_pkg;

    localparam logic [7:0] PERF_CTRL       = 8'h00;
    localparam logic [7:0] PERF_MCYCLE_LO  = 8'h04;
    localparam logic [7:0] PERF_MCYCLE_HI  = 8'h08;
    localparam logic [7:0] PERF_INSNRET_LO = 8'h10;
    localparam logic [7:0] PERF_INSNRET_HI = 8'h14;

    localparam logic [2:0] CNT_CLR  = 3'd0;
    localparam logic [2:0] CNT_RUN  = 3'd1;
    localparam logic [2:0] CNT_HOLD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first eligible requester at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!any && eligible[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/perf_cntr_arbiter.sv
// Shares one perf_cntr MMIO port among N_REQ requesters; one transaction per IDLE->ISSUE->RESP pass.
module perf_cntr_arbiter
    import perf_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 8,
    parameter int WW    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    we_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*WW-1:0] wdata_i,
    output logic [N_REQ-1:0]    ack_o,
    output logic [31:0]         rdata_o,
    output logic [AW-1:0]       pc_addr_o,
    output logic [WW-1:0]       pc_wdata_o,
    output logic                pc_w_en_o,
    input  logic [31:0]         pc_rdata_i,
    output state_t              dbg_state
);

    localparam int IW = $clog2(N_REQ);

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_idx;
    logic [N_REQ-1:0] eligible;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [AW-1:0]    addr_arr  [N_REQ];
    logic [WW-1:0]    wdata_arr [N_REQ];

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k]  = addr_i[k*AW +: AW];
            wdata_arr[k] = wdata_i[k*WW +: WW];
        end
    end

    // The requester being acked this cycle still has req_i high; keep it out of this grant.
    assign eligible  = req_i & ~ack_o;
    assign dbg_state = state;

    rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            ack_o      <= '0;
            rdata_o    <= '0;
            pc_addr_o  <= '0;
            pc_wdata_o <= '0;
            pc_w_en_o  <= 1'b0;
        end else begin
            ack_o     <= '0;
            pc_w_en_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx  <= pick_idx;
                        pc_addr_o  <= addr_arr[pick_idx];
                        pc_wdata_o <= wdata_arr[pick_idx];
                        pc_w_en_o  <= we_i[pick_idx];
                        rr_ptr     <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // perf_cntr registers its read data, so it is valid during this cycle.
                    rdata_o <= pc_rdata_i;
                    ack_o   <= N_REQ'(1) << grant_idx;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_cntr_arbiter.sv
// Bench for perf_cntr_arbiter with a behavioural perf_cntr and a transaction-level arbiter model.
module tb_perf_cntr_arbiter;
    import perf_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int WW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req   = '0;
    logic [N-1:0]    we    = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*WW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [31:0]     rdata;
    logic [AW-1:0]   pc_addr;
    logic [WW-1:0]   pc_wdata;
    logic            pc_w_en;
    logic [31:0]     pc_rdata = '0;
    state_t          dbg_state;

    perf_cntr_arbiter #(.N_REQ(N), .AW(AW), .WW(WW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .ack_o      (ack),
        .rdata_o    (rdata),
        .pc_addr_o  (pc_addr),
        .pc_wdata_o (pc_wdata),
        .pc_w_en_o  (pc_w_en),
        .pc_rdata_i (pc_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- behavioural perf_cntr ----------------
    logic [2:0]  pm_ctrl    = CNT_CLR;
    logic [63:0] pm_mcycle  = '0;
    logic [63:0] pm_instret = '0;

    function automatic logic [31:0] pm_read(input logic [7:0] a);
        case (a)
            PERF_CTRL:       return {29'd0, pm_ctrl};
            PERF_MCYCLE_LO:  return pm_mcycle[31:0];
            PERF_MCYCLE_HI:  return pm_mcycle[63:32];
            PERF_INSNRET_LO: return pm_instret[31:0];
            PERF_INSNRET_HI: return pm_instret[63:32];
            default:         return {24'hDEAD00, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pm_ctrl    <= CNT_CLR;
            pm_mcycle  <= '0;
            pm_instret <= '0;
            pc_rdata   <= '0;
        end else begin
            if (pc_w_en) pm_ctrl <= pc_wdata;
            if (pm_ctrl == CNT_CLR) begin
                pm_mcycle  <= '0;
                pm_instret <= '0;
            end else if (pm_ctrl == CNT_RUN) begin
                pm_mcycle  <= pm_mcycle + 64'd1;
                pm_instret <= pm_instret + {63'd0, pm_mcycle[0]};
            end
            pc_rdata <= pm_read(pc_addr);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Transaction view: a grant taken in cycle T puts the command on the counter port in T+1,
    // the counter's answer is sampled in T+2 and acked in T+3.
    int          m_phase = 0;   // 0 free, 1 command cycle, 2 answer cycle
    int          m_idx   = 0;
    int          m_rr    = 0;
    logic        m_we    = 1'b0;
    logic [7:0]  m_addr  = '0;
    logic [2:0]  m_wdata = '0;
    logic [N-1:0] m_ack  = '0;
    logic [31:0] m_rdata = '0;
    bit          armed   = 1'b0;
    logic [1:0]  exp_q[$];

    always @(negedge clk) begin
        logic [N-1:0] elig;
        int best, bestd, d;
        if (armed) begin
            check("ack", ack, m_ack);
            check("rdata", rdata, m_rdata);
            check("ack_onehot", $countones(ack) <= 1, 1);
            if (m_phase == 1) begin
                check("w_en_issue", pc_w_en, m_we);
                check("addr_issue", pc_addr, m_addr);
                check("wdata_issue", pc_wdata, m_wdata);
            end else begin
                check("w_en_idle", pc_w_en, 1'b0);
            end
            if (m_phase == 2) check("addr_resp", pc_addr, m_addr);
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", ack, '0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("ack_order", ack, 4'b0001 << e);
                end
            end
        end
        if (rst) begin
            m_phase = 0; m_ack = '0; m_rdata = '0; m_rr = 0;
            m_addr = '0; m_wdata = '0; m_we = 1'b0;
            exp_q.delete();
        end else if (m_phase == 0) begin
            elig  = req & ~m_ack;
            m_ack = '0;
            best  = -1;
            bestd = N;
            for (int k = 0; k < N; k++) begin
                d = (k - m_rr + N) % N;
                if (elig[k] && d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
            if (best >= 0) begin
                m_idx   = best;
                m_we    = we[best];
                m_addr  = addr[best*AW +: AW];
                m_wdata = wdata[best*WW +: WW];
                m_rr    = (best + 1) % N;
                m_phase = 1;
                exp_q.push_back(2'(best));
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_rdata = pc_rdata;
            m_ack   = 4'b0001 << m_idx;
            m_phase = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int k, input logic w, input logic [7:0] a, input logic [2:0] wd);
        we[k] = w;
        addr[k*AW +: AW] = a;
        wdata[k*WW +: WW] = wd;
        req[k] = 1'b1;
    endtask

    // Waits (bounded) for the next ack; lat counts cycles from the call, wen_cnt counts w_en cycles.
    task automatic wait_ack(input logic [N-1:0] keep, output int idx, output int lat, output int wen_cnt);
        idx = -1; lat = 0; wen_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (pc_w_en) wen_cnt++;
            if (ack != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (ack[k]) begin
                        idx = k;
                        if (!keep[k]) req[k] = 1'b0;
                    end
                end
                lat = c;
                break;
            end
        end
        if (idx < 0) check("ack_timeout", 1'b1, 1'b0);
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return PERF_CTRL;
            1: return PERF_MCYCLE_LO;
            2: return PERF_MCYCLE_HI;
            3: return PERF_INSNRET_LO;
            4: return PERF_INSNRET_HI;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic random_traffic(input int cycles);
        logic [N-1:0] keep;
        keep = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (c % 64 == 0) keep = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 249) == 0);
            for (int k = 0; k < N; k++) begin
                if (ack[k] && !keep[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    set_req(k, 1'($urandom_range(0, 1)), rand_addr(), 3'($urandom_range(0, 2)));
                end else if (req[k] && $urandom_range(0, 5) == 0) begin
                    // Fields churn while requesting; only the values present at grant matter.
                    set_req(k, 1'($urandom_range(0, 1)), rand_addr(), 3'($urandom_range(0, 7)));
                end
            end
        end
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int idx, lat, wen;

        // Reset held two cycles with every requester asking.
        rst = 1'b1;
        req = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            armed = 1'b1;
            check("rst_ack", ack, '0);
            check("rst_w_en", pc_w_en, 1'b0);
            check("rst_rdata", rdata, '0);
            check("rst_state", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        req = '0;
        @(posedge clk); #1;

        // Single write to start the counters, then a read of mcycle.
        set_req(0, 1'b1, PERF_CTRL, CNT_RUN);
        wait_ack('0, idx, lat, wen);
        check("wr_idx", idx, 0);
        check("wr_lat", lat, 3);
        check("wr_wen_cycles", wen, 1);
        repeat (10) @(posedge clk);
        #1;
        set_req(0, 1'b0, PERF_MCYCLE_LO, 3'd0);
        wait_ack('0, idx, lat, wen);
        check("rd_idx", idx, 0);
        check("rd_lat", lat, 3);
        check("rd_wen_cycles", wen, 0);
        check("rd_mcycle_nonzero", rdata != 0, 1'b1);
        // Answer sampled two counter ticks before the ack becomes visible.
        check("rd_mcycle", rdata, pm_mcycle[31:0] - 32'd2);

        // All four held: strict rotation, one ack every three cycles.
        apply_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, rand_addr(), 3'd0);
        for (int n = 0; n < 8; n++) begin
            wait_ack(4'hF, idx, lat, wen);
            check("rr_idx", idx, n % N);
            check("rr_lat", lat, 3);
        end
        req = '0;
        repeat (4) @(posedge clk);
        #1;

        // Pointer past requester 2 wraps to 0, then 1.
        apply_reset();
        set_req(2, 1'b0, PERF_MCYCLE_HI, 3'd0);
        wait_ack('0, idx, lat, wen);
        check("wrap_first", idx, 2);
        set_req(0, 1'b0, PERF_CTRL, 3'd0);
        set_req(1, 1'b0, PERF_INSNRET_LO, 3'd0);
        wait_ack('0, idx, lat, wen);
        check("wrap_idx0", idx, 0);
        check("wrap_lat0", lat, 3);
        wait_ack('0, idx, lat, wen);
        check("wrap_idx1", idx, 1);
        check("wrap_lat1", lat, 3);

        // Requester 1 holds req through its ack: masked for that cycle, regranted one cycle later.
        apply_reset();
        set_req(1, 1'b0, PERF_MCYCLE_LO, 3'd0);
        wait_ack(4'b0010, idx, lat, wen);
        check("mask_first", idx, 1);
        for (int n = 0; n < 3; n++) begin
            wait_ack(4'b0010, idx, lat, wen);
            check("mask_idx", idx, 1);
            check("mask_lat", lat, 4);
        end
        req = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset during the answer cycle of requester 2: dropped, then redone after release.
        apply_reset();
        set_req(2, 1'b0, PERF_MCYCLE_LO, 3'd0);
        @(posedge clk); #1;
        check("midrst_issue_state", dbg_state, ST_ISSUE);
        @(posedge clk); #1;
        check("midrst_resp_state", dbg_state, ST_RESP);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_ack", ack, '0);
        check("midrst_w_en", pc_w_en, 1'b0);
        check("midrst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        wait_ack('0, idx, lat, wen);
        check("midrst_idx", idx, 2);
        check("midrst_lat", lat, 3);

        // Random traffic with occasional resets, then drain.
        random_traffic(3000);
        req = '0;
        repeat (10) @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
